cordic_freq_discr: RTL and testbench

Phase-difference frequency discriminator placed directly downstream of the serial CORDIC magnitude/phase core. It detects each completed conversion from the core's level `rdy`, subtracts the previous phase modulo 2π to get instantaneous frequency, and applies magnitude-based squelch. It accumulates and dumps `DEC` differences into one averaged-frequency output word with a single-cycle valid strobe.

---
 rtl/cordic_freq_discr_pkg.sv | 23 ++
 rtl/cordic_freq_discr_if.sv | 24 ++
 rtl/cordic_freq_discr_acc_dump.sv | 54 +++++
 rtl/cordic_freq_discr.sv | 94 +++++++++
 tb/tb_cordic_freq_discr.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_freq_discr_pkg.sv
// Shared types and helpers for the CORDIC frequency discriminator.
// Provides the FSM state enum, accumulator width and phase-wrap helper.
package cordicDiscrPkg;

   typedef enum logic {
      PRIME,
      RUN
   } state_t;

   function automatic int accWdt(input int xy, input int dec);
      return xy + 1 + $clog2(dec);
   endfunction

   // Keeps the low xy+1 bits of d and sign-extends from bit xy,
   // folding a phase difference into [-pi, pi).
   function automatic logic signed [31:0] wrapPhase(
      input logic signed [31:0] d,
      input int xy
   );
      return (d <<< (31 - xy)) >>> (31 - xy);
   endfunction

endpackage

// File: rtl/cordic_freq_discr_if.sv
// Sample/result bundle between the CORDIC core side and the discriminator.
// master: drives rdy_in/mag/ph/thr, reads vld/freq/sq; slave: the reverse.
interface cordic_freq_discr_if #(
   parameter int XY_WDT = 14,
   parameter int ACC_W  = 17
);
   logic                    rdy_in;
   logic [XY_WDT-1:0]       mag;
   logic signed [XY_WDT+1:0] ph;
   logic [XY_WDT-1:0]       thr;
   logic                    vld;
   logic signed [ACC_W-1:0] freq;
   logic                    sq;

   modport master (
      output rdy_in, mag, ph, thr,
      input  vld, freq, sq
   );

   modport slave (
      input  rdy_in, mag, ph, thr,
      output vld, freq, sq
   );
endinterface

// File: rtl/cordic_freq_discr_acc_dump.sv
// Accumulate-and-dump: sums DEC signed inputs, emits one word + 1-cycle vld.
// Ports: clk, reset, en, sclr, in_vld, din -> vld, dout.
module cordic_acc_dump #(
   parameter int W   = 15,
   parameter int DEC = 4,
   parameter int OW  = 17
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 sclr,
   input  logic                 in_vld,
   input  logic signed [W-1:0]  din,
   output logic                 vld,
   output logic signed [OW-1:0] dout
);
   localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;

   logic signed [OW-1:0] acc;
   logic signed [OW-1:0] ext;
   logic [CW-1:0]        cnt;
   logic                 last;

   assign ext  = OW'(din);
   assign last = (cnt == CW'(DEC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         cnt  <= '0;
         vld  <= 1'b0;
         dout <= '0;
      end else if (en) begin
         if (sclr) begin
            acc <= '0;
            cnt <= '0;
            vld <= 1'b0;
         end else begin
            vld <= 1'b0;
            if (in_vld) begin
               if (last) begin
                  dout <= acc + ext;
                  vld  <= 1'b1;
                  acc  <= '0;
                  cnt  <= '0;
               end else begin
                  acc <= acc + ext;
                  cnt <= cnt + CW'(1);
               end
            end
         end
      end
   end
endmodule

// File: rtl/cordic_freq_discr.sv
// Phase-difference frequency discriminator with magnitude squelch.
// Ports: clk, reset, sclr, en, bus (slave: rdy_in/mag/ph/thr -> vld/freq/sq).
module cordic_freq_discr
   import cordicDiscrPkg::*;
#(
   parameter int XY_WDT = 14,
   parameter int DEC    = 4,
   parameter int SQ_N   = 3,
   parameter int ACC_W  = accWdt(XY_WDT, DEC)
) (
   input logic             clk,
   input logic             reset,
   input logic             sclr,
   input logic             en,
   cordic_freq_discr_if.slave bus
);
   localparam int PW = XY_WDT + 2;
   localparam int DW = XY_WDT + 1;
   localparam int LW = $clog2(SQ_N + 1);

   state_t               state;
   logic                 rdy_d;
   logic                 sq;
   logic                 accept;
   logic                 lo;
   logic                 sq_nxt;
   logic                 in_vld;
   logic [LW-1:0]        lo_cnt;
   logic [LW-1:0]        lo_nxt;
   logic signed [PW-1:0] ph_prev;
   logic signed [PW:0]   d;
   logic signed [DW-1:0] dw;
   logic signed [DW-1:0] din;

   // rdy_d resets high so the core's idle rdy=1 is not a sample.
   assign accept = bus.rdy_in & ~rdy_d;
   assign lo     = bus.mag < bus.thr;

   always_comb begin
      lo_nxt = '0;
      if (lo) begin
         lo_nxt = (lo_cnt == LW'(SQ_N)) ? lo_cnt : lo_cnt + LW'(1);
      end
   end

   assign sq_nxt = lo & (lo_nxt == LW'(SQ_N));

   assign d  = {bus.ph[PW-1], bus.ph} - {ph_prev[PW-1], ph_prev};
   assign dw = DW'(wrapPhase(32'(d), XY_WDT));

   // The sample that trips squelch already contributes zero.
   assign din    = sq_nxt ? '0 : dw;
   assign in_vld = accept & (state == RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= PRIME;
         rdy_d   <= 1'b1;
         ph_prev <= '0;
         lo_cnt  <= '0;
         sq      <= 1'b0;
      end else if (en) begin
         rdy_d <= bus.rdy_in;
         if (sclr) begin
            state  <= PRIME;
            rdy_d  <= 1'b1;
            lo_cnt <= '0;
            sq     <= 1'b0;
         end else if (accept) begin
            ph_prev <= bus.ph;
            lo_cnt  <= lo_nxt;
            sq      <= sq_nxt;
            state   <= RUN;
         end
      end
   end

   assign bus.sq = sq;

   cordic_acc_dump #(
      .W   (DW),
      .DEC (DEC),
      .OW  (ACC_W)
   ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .sclr   (sclr),
      .in_vld (in_vld),
      .din    (din),
      .vld    (bus.vld),
      .dout   (bus.freq)
   );
endmodule

// File: tb/tb_cordic_freq_discr.sv
// Directed bench for cordic_freq_discr: DEC=1 and DEC=4 instances
// share stimulus; each task checks its own scenario inline.
module tb_cordic_freq_discr;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sclr = 1'b0;
   logic en = 1'b1;
   logic rdy_in = 1'b1;
   logic [13:0] mag = '0;
   logic signed [15:0] ph = '0;
   logic [13:0] thr = '0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cordic_freq_discr_if #(.XY_WDT(14), .ACC_W(15)) if1 ();
   cordic_freq_discr_if #(.XY_WDT(14), .ACC_W(17)) if4 ();

   assign if1.rdy_in = rdy_in;
   assign if1.mag    = mag;
   assign if1.ph     = ph;
   assign if1.thr    = thr;
   assign if4.rdy_in = rdy_in;
   assign if4.mag    = mag;
   assign if4.ph     = ph;
   assign if4.thr    = thr;

   cordic_freq_discr #(.XY_WDT(14), .DEC(1), .SQ_N(3)) u1 (
      .clk(clk), .reset(reset), .sclr(sclr), .en(en), .bus(if1.slave)
   );
   cordic_freq_discr #(.XY_WDT(14), .DEC(4), .SQ_N(3)) u4 (
      .clk(clk), .reset(reset), .sclr(sclr), .en(en), .bus(if4.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic conv(input int p, input int m);
      rdy_in = 1'b0;
      tick();
      ph = 16'(p);
      mag = 14'(m);
      rdy_in = 1'b1;
      tick();
   endtask

   task automatic do_sclr();
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (if1.vld !== 1'b0 || if1.freq !== 15'sd0 || if1.sq !== 1'b0) begin
         errors++;
         $display("FAIL reset: vld=%b freq=%0d sq=%b want 0/0/0",
                  if1.vld, if1.freq, if1.sq);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_level_rdy();
      ph = 16'sd5000;
      rdy_in = 1'b1;
      repeat (10) tick();
      conv(0, 0);
      checks++;
      if (if1.vld !== 1'b0) begin
         errors++;
         $display("FAIL level_rdy_prime: vld=%b want 0 freq=%0d",
                  if1.vld, if1.freq);
      end
   endtask

   task automatic test_baseline();
      conv(1000, 0);
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== 15'sd1000) begin
         errors++;
         $display("FAIL base_1: vld=%b freq=%0d want 1/1000",
                  if1.vld, if1.freq);
      end
      repeat (3) tick();
      checks++;
      if (if1.vld !== 1'b0) begin
         errors++;
         $display("FAIL base_pulse: vld=%b want 0", if1.vld);
      end
      conv(2000, 0);
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== 15'sd1000) begin
         errors++;
         $display("FAIL base_2: vld=%b freq=%0d want 1/1000",
                  if1.vld, if1.freq);
      end
      conv(1500, 0);
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== -15'sd500) begin
         errors++;
         $display("FAIL base_3: vld=%b freq=%0d want 1/-500",
                  if1.vld, if1.freq);
      end
   endtask

   task automatic test_wrap();
      do_sclr();
      conv(16000, 0);
      conv(-16000, 0);
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== 15'sd768) begin
         errors++;
         $display("FAIL wrap_neg: freq=%0d want 768", if1.freq);
      end
      conv(16000, 0);
      checks++;
      if (if1.freq !== -15'sd768) begin
         errors++;
         $display("FAIL wrap_pos: freq=%0d want -768", if1.freq);
      end
      conv(16384, 0);
      conv(-16383, 0);
      checks++;
      if (if1.freq !== 15'sd1) begin
         errors++;
         $display("FAIL wrap_pi: freq=%0d want 1", if1.freq);
      end
      conv(-8192, 0);
      conv(8192, 0);
      checks++;
      if (if1.freq !== -15'sd16384) begin
         errors++;
         $display("FAIL wrap_exact_pi: freq=%0d want -16384", if1.freq);
      end
   endtask

   task automatic test_decimation();
      do_sclr();
      conv(0, 0);
      conv(300, 0);
      conv(600, 0);
      conv(900, 0);
      checks++;
      if (if4.vld !== 1'b0) begin
         errors++;
         $display("FAIL dec_early: vld=%b want 0", if4.vld);
      end
      conv(1200, 0);
      checks++;
      if (if4.vld !== 1'b1 || if4.freq !== 17'sd1200) begin
         errors++;
         $display("FAIL dec_sum: vld=%b freq=%0d want 1/1200",
                  if4.vld, if4.freq);
      end
      tick();
      checks++;
      if (if4.vld !== 1'b0) begin
         errors++;
         $display("FAIL dec_pulse: vld=%b want 0", if4.vld);
      end
      conv(1500, 0);
      conv(1800, 0);
      conv(2100, 0);
      conv(2600, 0);
      checks++;
      if (if4.vld !== 1'b1 || if4.freq !== 17'sd1400) begin
         errors++;
         $display("FAIL dec_restart: vld=%b freq=%0d want 1/1400",
                  if4.vld, if4.freq);
      end
   endtask

   task automatic test_squelch();
      thr = 14'd100;
      do_sclr();
      conv(0, 500);
      conv(100, 50);
      conv(300, 50);
      checks++;
      if (if1.sq !== 1'b0 || if1.freq !== 15'sd200) begin
         errors++;
         $display("FAIL sq_pre: sq=%b freq=%0d want 0/200",
                  if1.sq, if1.freq);
      end
      conv(600, 50);
      checks++;
      if (if1.sq !== 1'b1 || if1.vld !== 1'b1 || if1.freq !== 15'sd0) begin
         errors++;
         $display("FAIL sq_set: sq=%b vld=%b freq=%0d want 1/1/0",
                  if1.sq, if1.vld, if1.freq);
      end
      conv(650, 200);
      checks++;
      if (if1.sq !== 1'b0 || if1.freq !== 15'sd50) begin
         errors++;
         $display("FAIL sq_clr: sq=%b freq=%0d want 0/50",
                  if1.sq, if1.freq);
      end
      checks++;
      if (if4.vld !== 1'b1 || if4.freq !== 17'sd350) begin
         errors++;
         $display("FAIL sq_dec: vld=%b freq=%0d want 1/350",
                  if4.vld, if4.freq);
      end
      thr = 14'd0;
   endtask

   task automatic test_sclr();
      do_sclr();
      conv(0, 0);
      conv(100, 0);
      rdy_in = 1'b0;
      tick();
      ph = 16'sd500;
      rdy_in = 1'b1;
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      checks++;
      if (if1.vld !== 1'b0 || if1.freq !== 15'sd100) begin
         errors++;
         $display("FAIL sclr_accept: vld=%b freq=%0d want 0/100",
                  if1.vld, if1.freq);
      end
      conv(700, 0);
      checks++;
      if (if1.vld !== 1'b0) begin
         errors++;
         $display("FAIL sclr_prime: vld=%b want 0", if1.vld);
      end
      conv(900, 0);
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== 15'sd200) begin
         errors++;
         $display("FAIL sclr_run: vld=%b freq=%0d want 1/200",
                  if1.vld, if1.freq);
      end
   endtask

   task automatic test_enable();
      do_sclr();
      conv(0, 0);
      conv(100, 0);
      en = 1'b0;
      ph = 16'sd9999;
      for (int i = 0; i < 5; i++) begin
         rdy_in = (i % 2 == 0);
         tick();
      end
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== 15'sd100) begin
         errors++;
         $display("FAIL en_freeze: vld=%b freq=%0d want 1/100",
                  if1.vld, if1.freq);
      end
      en = 1'b1;
      tick();
      checks++;
      if (if1.vld !== 1'b0) begin
         errors++;
         $display("FAIL en_resume: vld=%b want 0", if1.vld);
      end
      conv(250, 0);
      checks++;
      if (if1.freq !== 15'sd150) begin
         errors++;
         $display("FAIL en_next: freq=%0d want 150", if1.freq);
      end
      rdy_in = 1'b0;
      tick();
      en = 1'b0;
      ph = 16'sd400;
      rdy_in = 1'b1;
      repeat (3) tick();
      checks++;
      if (if1.vld !== 1'b0) begin
         errors++;
         $display("FAIL en_hold: vld=%b want 0", if1.vld);
      end
      en = 1'b1;
      tick();
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== 15'sd150) begin
         errors++;
         $display("FAIL en_late_accept: vld=%b freq=%0d want 1/150",
                  if1.vld, if1.freq);
      end
   endtask

   task automatic test_async_reset();
      do_sclr();
      conv(0, 0);
      conv(100, 0);
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== 15'sd100) begin
         errors++;
         $display("FAIL ar_pre: vld=%b freq=%0d want 1/100",
                  if1.vld, if1.freq);
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (if1.vld !== 1'b0 || if1.freq !== 15'sd0 ||
          if4.freq !== 17'sd0) begin
         errors++;
         $display("FAIL ar_now: vld=%b freq=%0d freq4=%0d want 0/0/0",
                  if1.vld, if1.freq, if4.freq);
      end
      #2;
      reset = 1'b0;
      tick();
      conv(200, 0);
      checks++;
      if (if1.vld !== 1'b0) begin
         errors++;
         $display("FAIL ar_prime: vld=%b want 0", if1.vld);
      end
      conv(300, 0);
      checks++;
      if (if1.vld !== 1'b1 || if1.freq !== 15'sd100) begin
         errors++;
         $display("FAIL ar_run: vld=%b freq=%0d want 1/100",
                  if1.vld, if1.freq);
      end
      conv(400, 0);
      conv(500, 0);
      checks++;
      if (if4.vld !== 1'b0) begin
         errors++;
         $display("FAIL ar_dec_early: vld=%b want 0", if4.vld);
      end
      conv(600, 0);
      checks++;
      if (if4.vld !== 1'b1 || if4.freq !== 17'sd400) begin
         errors++;
         $display("FAIL ar_dec_sum: vld=%b freq=%0d want 1/400",
                  if4.vld, if4.freq);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: timeout, checks=%0d errors=%0d",
               checks, errors);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_level_rdy();
      test_baseline();
      test_wrap();
      test_decimation();
      test_squelch();
      test_sclr();
      test_enable();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
